// File: rtl/cricket_pkg.sv
// Shared types and outcome helpers for the T20 scoring engine.
package cricket_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INN1,
    BREAK,
    INN2,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    DOT,
    RUN,
    EXTRA,
    WICKET
  } outcome_class_t;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_TEAM1 = 2'b01;
  localparam logic [1:0] WIN_TEAM2 = 2'b10;
  localparam logic [1:0] WIN_TIE   = 2'b11;

  // Classify a raw random code into dot / scoring / extra / wicket.
  function automatic outcome_class_t outcome_class(input logic [3:0] code);
    outcome_class_t cls;
    if (code <= 4'd2)       cls = DOT;
    else if (code <= 4'd12) cls = RUN;
    else if (code <= 4'd14) cls = EXTRA;
    else                    cls = WICKET;
    return cls;
  endfunction

  // Runs credited to the batting side for a raw code (extras carry one run).
  function automatic logic [2:0] outcome_runs(input logic [3:0] code);
    logic [2:0] value;
    case (code)
      4'd3, 4'd4, 4'd5, 4'd6: value = 3'd1;
      4'd7, 4'd8, 4'd9:       value = 3'd2;
      4'd10:                  value = 3'd3;
      4'd11:                  value = 3'd4;
      4'd12:                  value = 3'd6;
      4'd13, 4'd14:           value = 3'd1;
      default:                value = 3'd0;
    endcase
    return value;
  endfunction

endpackage

// File: rtl/outcome_decoder.sv
// Combinational decode of one raw ball code into run value and ball type.
module outcome_decoder
  import cricket_pkg::*;
(
  input  logic [3:0] ball_outcome,
  output logic [2:0] run_value,
  output logic       is_legal,
  output logic       is_wicket
);

  outcome_class_t cls;

  // Wides and no-balls are the only deliveries that do not count as a ball.
  always_comb begin
    cls       = outcome_class(ball_outcome);
    run_value = outcome_runs(ball_outcome);
    is_legal  = (cls != EXTRA);
    is_wicket = (cls == WICKET);
  end

endmodule

// File: rtl/innings_scorer.sv
// Two-innings T20 scoring engine: ball intake, counters, innings close, result.
module innings_scorer
  import cricket_pkg::*;
#(
  parameter int unsigned BALLS_PER_OVER = 6,
  parameter int unsigned MAX_OVERS      = 20,
  parameter int unsigned MAX_WKTS       = 10,
  parameter int unsigned RUN_W          = 9,
  localparam int unsigned OVR_W         = $clog2(MAX_OVERS + 1),
  localparam int unsigned BIO_W         = $clog2(BALLS_PER_OVER)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ball_valid,
  input  logic [3:0]       ball_outcome,
  output logic             ball_ready,
  output logic             innings,
  output logic [RUN_W-1:0] runs,
  output logic [3:0]       wickets,
  output logic [OVR_W-1:0] overs,
  output logic [BIO_W-1:0] ball_in_over,
  output logic [RUN_W-1:0] team1_runs,
  output logic [RUN_W-1:0] team2_runs,
  output logic [3:0]       team1_wkts,
  output logic [3:0]       team2_wkts,
  output logic [RUN_W-1:0] target,
  output logic             innings_done,
  output logic             match_over,
  output logic [1:0]       winner
);

  localparam int unsigned SUM_W = RUN_W + 1;

  state_t           state, state_d;
  logic [2:0]       run_value;
  logic             is_legal, is_wicket;
  logic             accept, closing;
  logic [SUM_W-1:0] ball_sum, target_sum;
  logic [RUN_W-1:0] runs_new, target_load;
  logic [3:0]       wkts_new;
  logic [OVR_W-1:0] overs_new;
  logic [BIO_W-1:0] bio_new;

  logic             ball_ready_d, innings_d, innings_done_d, match_over_d;
  logic [RUN_W-1:0] runs_d, team1_runs_d, team2_runs_d, target_d;
  logic [3:0]       wickets_d, team1_wkts_d, team2_wkts_d;
  logic [OVR_W-1:0] overs_d;
  logic [BIO_W-1:0] bio_d;
  logic [1:0]       winner_d;

  outcome_decoder u_decoder (
    .ball_outcome (ball_outcome),
    .run_value    (run_value),
    .is_legal     (is_legal),
    .is_wicket    (is_wicket)
  );

  // Post-ball counter values, saturating runs, and the innings close test.
  always_comb begin
    accept     = ball_valid && ball_ready;
    ball_sum   = SUM_W'(runs) + SUM_W'(run_value);
    runs_new   = ball_sum[RUN_W] ? '1 : ball_sum[RUN_W-1:0];
    wkts_new   = wickets + 4'(is_wicket);
    overs_new  = overs;
    bio_new    = ball_in_over;
    if (is_legal) begin
      if (ball_in_over == BIO_W'(BALLS_PER_OVER - 1)) begin
        bio_new   = '0;
        overs_new = overs + OVR_W'(1);
      end else begin
        bio_new = ball_in_over + BIO_W'(1);
      end
    end
    closing     = (wkts_new == 4'(MAX_WKTS)) || (overs_new == OVR_W'(MAX_OVERS)) ||
                  ((state == INN2) && (runs_new >= target));
    target_sum  = SUM_W'(team1_runs) + SUM_W'(1);
    target_load = target_sum[RUN_W] ? '1 : target_sum[RUN_W-1:0];
  end

  // Next-state and next-output logic for the match sequence.
  always_comb begin
    state_d        = state;
    runs_d         = runs;
    wickets_d      = wickets;
    overs_d        = overs;
    bio_d          = ball_in_over;
    team1_runs_d   = team1_runs;
    team2_runs_d   = team2_runs;
    team1_wkts_d   = team1_wkts;
    team2_wkts_d   = team2_wkts;
    target_d       = target;
    winner_d       = winner;
    innings_done_d = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_d      = INN1;
          runs_d       = '0;
          wickets_d    = '0;
          overs_d      = '0;
          bio_d        = '0;
          team1_runs_d = '0;
          team2_runs_d = '0;
          team1_wkts_d = '0;
          team2_wkts_d = '0;
          target_d     = '0;
          winner_d     = WIN_NONE;
        end
      end
      INN1, INN2: begin
        if (accept) begin
          runs_d    = runs_new;
          wickets_d = wkts_new;
          overs_d   = overs_new;
          bio_d     = bio_new;
          if (state == INN1) begin
            team1_runs_d = runs_new;
            team1_wkts_d = wkts_new;
          end else begin
            team2_runs_d = runs_new;
            team2_wkts_d = wkts_new;
          end
          if (closing) begin
            innings_done_d = 1'b1;
            if (state == INN1) begin
              state_d = BREAK;
            end else begin
              state_d = DONE;
              if (runs_new > team1_runs)       winner_d = WIN_TEAM2;
              else if (runs_new == team1_runs) winner_d = WIN_TIE;
              else                             winner_d = WIN_TEAM1;
            end
          end
        end
      end
      BREAK: begin
        state_d   = INN2;
        target_d  = target_load;
        runs_d    = '0;
        wickets_d = '0;
        overs_d   = '0;
        bio_d     = '0;
      end
      default: state_d = IDLE;
    endcase
    innings_d    = (state_d == BREAK) || (state_d == INN2) || (state_d == DONE);
    ball_ready_d = (state_d == INN1) || (state_d == INN2);
    match_over_d = (state_d == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ball_ready   <= 1'b0;
      innings      <= 1'b0;
      runs         <= '0;
      wickets      <= '0;
      overs        <= '0;
      ball_in_over <= '0;
      team1_runs   <= '0;
      team2_runs   <= '0;
      team1_wkts   <= '0;
      team2_wkts   <= '0;
      target       <= '0;
      innings_done <= 1'b0;
      match_over   <= 1'b0;
      winner       <= WIN_NONE;
    end else begin
      state        <= state_d;
      ball_ready   <= ball_ready_d;
      innings      <= innings_d;
      runs         <= runs_d;
      wickets      <= wickets_d;
      overs        <= overs_d;
      ball_in_over <= bio_d;
      team1_runs   <= team1_runs_d;
      team2_runs   <= team2_runs_d;
      team1_wkts   <= team1_wkts_d;
      team2_wkts   <= team2_wkts_d;
      target       <= target_d;
      innings_done <= innings_done_d;
      match_over   <= match_over_d;
      winner       <= winner_d;
    end
  end

endmodule

// File: tb/tb_innings_scorer.sv
// Self-checking bench for innings_scorer: directed scenarios plus random matches.
`timescale 1ns/1ps
module tb_innings_scorer;

  logic       clk = 1'b0;
  logic       rst, start, ball_valid;
  logic [3:0] ball_outcome;
  logic       ball_ready, innings, innings_done, match_over;
  logic [8:0] runs, team1_runs, team2_runs, target;
  logic [3:0] wickets, team1_wkts, team2_wkts;
  logic [4:0] overs;
  logic [2:0] ball_in_over;
  logic [1:0] winner;

  logic       s_start, s_valid;
  logic [3:0] s_outcome;
  logic       s_ready, s_innings, s_done, s_over;
  logic [3:0] s_runs, s_t1r, s_t2r, s_target, s_wkts, s_t1w, s_t2w;
  logic [4:0] s_overs;
  logic [2:0] s_bio;
  logic [1:0] s_winner;

  int checks = 0;
  int failures = 0;

  // Reference model state: per-team runs/wickets, legal balls this innings.
  int rv[16] = '{0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 3, 4, 6, 1, 1, 0};
  int m_runs[2];
  int m_wk[2];
  int m_legal, m_inn, m_target;

  innings_scorer u_dut (
    .clk(clk), .rst(rst), .start(start), .ball_valid(ball_valid),
    .ball_outcome(ball_outcome), .ball_ready(ball_ready), .innings(innings),
    .runs(runs), .wickets(wickets), .overs(overs), .ball_in_over(ball_in_over),
    .team1_runs(team1_runs), .team2_runs(team2_runs), .team1_wkts(team1_wkts),
    .team2_wkts(team2_wkts), .target(target), .innings_done(innings_done),
    .match_over(match_over), .winner(winner)
  );

  innings_scorer #(.RUN_W(4)) u_small (
    .clk(clk), .rst(rst), .start(s_start), .ball_valid(s_valid),
    .ball_outcome(s_outcome), .ball_ready(s_ready), .innings(s_innings),
    .runs(s_runs), .wickets(s_wkts), .overs(s_overs), .ball_in_over(s_bio),
    .team1_runs(s_t1r), .team2_runs(s_t2r), .team1_wkts(s_t1w),
    .team2_wkts(s_t2w), .target(s_target), .innings_done(s_done),
    .match_over(s_over), .winner(s_winner)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    rst = 1'b1; start = 1'b0; ball_valid = 1'b0; ball_outcome = 4'd0;
    s_start = 1'b0; s_valid = 1'b0; s_outcome = 4'd0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_ball(input int code);
    ball_valid = 1'b1;
    ball_outcome = 4'(code);
    @(posedge clk); #1;
    ball_valid = 1'b0;
  endtask

  task automatic feed(input int code, input int n);
    repeat (n) send_ball(code);
  endtask

  task automatic model_reset();
    m_runs = '{0, 0}; m_wk = '{0, 0};
    m_legal = 0; m_inn = 0; m_target = 0;
  endtask

  task automatic model_ball(input int code, output bit closed);
    m_runs[m_inn] = (m_runs[m_inn] + rv[code] > 511) ? 511 : m_runs[m_inn] + rv[code];
    if (code == 15) m_wk[m_inn]++;
    if (code != 13 && code != 14) m_legal++;
    closed = (m_wk[m_inn] == 10) || (m_legal == 120) ||
             (m_inn == 1 && m_runs[1] >= m_target);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; ball_valid = 1'b0; ball_outcome = 4'd0;
    s_start = 1'b0; s_valid = 1'b0; s_outcome = 4'd0;
    @(posedge clk); #1;
    checks++;
    if ({ball_ready, innings, runs, wickets, overs, ball_in_over, team1_runs, team2_runs,
         team1_wkts, team2_wkts, target, innings_done, match_over, winner} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got ready=%b inn=%b runs=%0d tgt=%0d win=%b want all 0",
               ball_ready, innings, runs, target, winner);
    end
    checks++;
    if ({s_ready, s_runs, s_t1r, s_over} !== '0) begin
      failures++;
      $display("FAIL reset_small got ready=%b runs=%0d want 0", s_ready, s_runs);
    end
    rst = 1'b0;
  endtask

  task automatic test_overs_exhausted();
    apply_reset(); do_start();
    feed(4, 119);
    checks++;
    if ({innings_done, ball_ready, overs, ball_in_over} !== {1'b0, 1'b1, 5'd19, 3'd5}) begin
      failures++;
      $display("FAIL overs_119 got done=%b ready=%b ov=%0d bio=%0d want 0 1 19 5",
               innings_done, ball_ready, overs, ball_in_over);
    end
    send_ball(4);
    checks++;
    if ({innings_done, ball_ready, innings} !== 3'b101) begin
      failures++;
      $display("FAIL overs_close got done=%b ready=%b inn=%b want 1 0 1",
               innings_done, ball_ready, innings);
    end
    checks++;
    if ({team1_runs, overs, team1_wkts} !== {9'd120, 5'd20, 4'd0}) begin
      failures++;
      $display("FAIL overs_totals got runs=%0d ov=%0d wk=%0d want 120 20 0",
               team1_runs, overs, team1_wkts);
    end
    @(posedge clk); #1;
    checks++;
    if ({target, runs, overs, innings_done, ball_ready} !== {9'd121, 9'd0, 5'd0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL overs_inn2_entry got tgt=%0d runs=%0d ov=%0d done=%b ready=%b want 121 0 0 0 1",
               target, runs, overs, innings_done, ball_ready);
    end
  endtask

  task automatic test_start_ignored();
    do_start();
    @(posedge clk); #1;
    checks++;
    if ({innings, target, ball_ready, match_over} !== {1'b1, 9'd121, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL start_in_inn2 got inn=%b tgt=%0d ready=%b over=%b want 1 121 1 0",
               innings, target, ball_ready, match_over);
    end
  endtask

  task automatic test_all_out();
    apply_reset(); do_start();
    feed(15, 9);
    checks++;
    if ({innings_done, wickets} !== {1'b0, 4'd9}) begin
      failures++;
      $display("FAIL allout_9 got done=%b wk=%0d want 0 9", innings_done, wickets);
    end
    send_ball(15);
    checks++;
    if ({innings_done, ball_ready, team1_wkts, overs, ball_in_over, team1_runs} !==
        {1'b1, 1'b0, 4'd10, 5'd1, 3'd4, 9'd0}) begin
      failures++;
      $display("FAIL allout_close got done=%b ready=%b wk=%0d ov=%0d bio=%0d runs=%0d want 1 0 10 1 4 0",
               innings_done, ball_ready, team1_wkts, overs, ball_in_over, team1_runs);
    end
  endtask

  task automatic test_extras();
    apply_reset(); do_start();
    repeat (5) begin send_ball(13); send_ball(14); end
    checks++;
    if ({runs, overs, ball_in_over} !== {9'd10, 5'd0, 3'd0}) begin
      failures++;
      $display("FAIL extras_only got runs=%0d ov=%0d bio=%0d want 10 0 0", runs, overs, ball_in_over);
    end
    send_ball(11);
    checks++;
    if ({runs, team1_runs, wickets, overs, ball_in_over} !== {9'd14, 9'd14, 4'd0, 5'd0, 3'd1}) begin
      failures++;
      $display("FAIL extras_four got runs=%0d t1=%0d wk=%0d ov=%0d bio=%0d want 14 14 0 0 1",
               runs, team1_runs, wickets, overs, ball_in_over);
    end
  endtask

  task automatic test_chase();
    apply_reset(); do_start();
    feed(12, 5); feed(15, 10);
    checks++;
    if ({innings_done, team1_runs} !== {1'b1, 9'd30}) begin
      failures++;
      $display("FAIL chase_inn1 got done=%b t1=%0d want 1 30", innings_done, team1_runs);
    end
    ball_valid = 1'b1; ball_outcome = 4'd12;
    @(posedge clk); #1;
    ball_valid = 1'b0;
    checks++;
    if ({runs, team2_runs, target, ball_ready, innings} !== {9'd0, 9'd0, 9'd31, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL break_hold got runs=%0d t2=%0d tgt=%0d ready=%b inn=%b want 0 0 31 1 1",
               runs, team2_runs, target, ball_ready, innings);
    end
    feed(12, 5);
    checks++;
    if ({runs, match_over, innings_done} !== {9'd30, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL chase_30 got runs=%0d over=%b done=%b want 30 0 0", runs, match_over, innings_done);
    end
    send_ball(3);
    checks++;
    if ({team2_runs, winner, match_over, innings_done, ball_ready} !==
        {9'd31, 2'b10, 1'b1, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL chase_won got t2=%0d win=%b over=%b done=%b ready=%b want 31 10 1 1 0",
               team2_runs, winner, match_over, innings_done, ball_ready);
    end
    @(posedge clk); #1;
    checks++;
    if ({innings_done, match_over, winner, runs} !== {1'b0, 1'b1, 2'b10, 9'd31}) begin
      failures++;
      $display("FAIL done_hold got done=%b over=%b win=%b runs=%0d want 0 1 10 31",
               innings_done, match_over, winner, runs);
    end
  endtask

  task automatic test_tie_and_restart();
    apply_reset(); do_start();
    feed(12, 5); feed(15, 10);
    @(posedge clk); #1;
    feed(3, 30); feed(0, 89);
    checks++;
    if (match_over !== 1'b0) begin
      failures++;
      $display("FAIL tie_early got over=%b want 0", match_over);
    end
    send_ball(0);
    checks++;
    if ({winner, match_over, team2_runs, overs} !== {2'b11, 1'b1, 9'd30, 5'd20}) begin
      failures++;
      $display("FAIL tie_result got win=%b over=%b t2=%0d ov=%0d want 11 1 30 20",
               winner, match_over, team2_runs, overs);
    end
    do_start();
    checks++;
    if ({ball_ready, innings, runs, team1_runs, team2_runs, target, winner, match_over, overs} !==
        {1'b1, 1'b0, 9'd0, 9'd0, 9'd0, 9'd0, 2'b00, 1'b0, 5'd0}) begin
      failures++;
      $display("FAIL restart_clear got ready=%b inn=%b t1=%0d t2=%0d tgt=%0d win=%b want 1 0 0 0 0 00",
               ball_ready, innings, team1_runs, team2_runs, target, winner);
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    s_start = 1'b1; @(posedge clk); #1; s_start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      s_valid = 1'b1; s_outcome = 4'd12;
      @(posedge clk); #1;
      s_valid = 1'b0;
      checks++;
      if (s_runs !== 4'((6 * k > 15) ? 15 : 6 * k)) begin
        failures++;
        $display("FAIL sat_runs ball=%0d got %0d want %0d", k, s_runs, (6 * k > 15) ? 15 : 6 * k);
      end
    end
    checks++;
    if ({s_t1r, s_done} !== {4'd15, 1'b0}) begin
      failures++;
      $display("FAIL sat_total got t1=%0d done=%b want 15 0", s_t1r, s_done);
    end
  endtask

  task automatic test_rst_mid();
    apply_reset(); do_start();
    feed(15, 10);
    @(posedge clk); #1;
    feed(12, 2);
    ball_valid = 1'b1; ball_outcome = 4'd12;
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({ball_ready, innings, runs, team1_runs, team2_runs, team1_wkts, target} !== '0) begin
      failures++;
      $display("FAIL rst_async got ready=%b inn=%b runs=%0d t1w=%0d tgt=%0d want 0",
               ball_ready, innings, runs, team1_wkts, target);
    end
    @(posedge clk); #1;
    checks++;
    if ({ball_ready, runs, team2_runs, match_over, winner} !== '0) begin
      failures++;
      $display("FAIL rst_held got ready=%b runs=%0d t2=%0d want 0", ball_ready, runs, team2_runs);
    end
    rst = 1'b0; ball_valid = 1'b0;
    do_start();
    send_ball(11);
    checks++;
    if ({ball_ready, innings, runs, team1_runs, ball_in_over} !== {1'b1, 1'b0, 9'd4, 9'd4, 3'd1}) begin
      failures++;
      $display("FAIL rst_restart got ready=%b inn=%b runs=%0d bio=%0d want 1 0 4 1",
               ball_ready, innings, runs, ball_in_over);
    end
  endtask

  task automatic test_random_matches();
    logic [50:0] act, exp;
    bit closed, done;
    int code, cycles, exp_w;
    apply_reset();
    for (int m = 0; m < 20; m++) begin
      do_start(); model_reset();
      done = 0; cycles = 0;
      while (!done && cycles < 2000) begin
        cycles++;
        closed = 0;
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk); #1;
        end else begin
          code = ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 15));
          send_ball(code);
          model_ball(code, closed);
        end
        act = {innings, runs, wickets, overs, ball_in_over, team1_runs, team2_runs,
               team1_wkts, team2_wkts, innings_done, ball_ready, match_over};
        exp = {(closed || m_inn == 1), 9'(m_runs[m_inn]), 4'(m_wk[m_inn]), 5'(m_legal / 6),
               3'(m_legal % 6), 9'(m_runs[0]), 9'(m_runs[1]), 4'(m_wk[0]), 4'(m_wk[1]),
               closed, !closed, (closed && m_inn == 1)};
        checks++;
        if (act !== exp) begin
          failures++;
          $display("FAIL rand_view match=%0d cycle=%0d got %h want %h", m, cycles, act, exp);
        end
        if (closed && m_inn == 0) begin
          @(posedge clk); #1;
          m_target = (m_runs[0] + 1 > 511) ? 511 : m_runs[0] + 1;
          m_inn = 1; m_legal = 0;
          checks++;
          if ({target, ball_ready, innings_done, runs} !== {9'(m_target), 1'b1, 1'b0, 9'd0}) begin
            failures++;
            $display("FAIL rand_inn2_entry match=%0d got tgt=%0d ready=%b want tgt=%0d ready=1",
                     m, target, ball_ready, m_target);
          end
        end else if (closed) begin
          exp_w = (m_runs[1] > m_runs[0]) ? 2 : ((m_runs[1] == m_runs[0]) ? 3 : 1);
          checks++;
          if (winner !== 2'(exp_w)) begin
            failures++;
            $display("FAIL rand_winner match=%0d got %0d want %0d (t1=%0d t2=%0d)",
                     m, winner, exp_w, m_runs[0], m_runs[1]);
          end
          done = 1;
        end
      end
      if (!done) begin
        checks++; failures++;
        $display("FAIL rand_timeout match=%0d got no result after %0d cycles want match end", m, cycles);
      end
    end
  endtask

  initial begin
    test_reset();
    test_overs_exhausted();
    test_start_ignored();
    test_all_out();
    test_extras();
    test_chase();
    test_tie_and_restart();
    test_saturation();
    test_rst_mid();
    test_random_matches();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
